i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
I2C target (responder) that pairs with the team's i2c_master on the same open-drain scl/sda bus. Oversamples scl/sda on the system clock, detects START/STOP, matches a 7-bit address, acknowledges, and handles both directions. Write bytes go out on rx_data/rx_valid; read bytes come in on tx_data in response to tx_req. No clock stretching: scl is input only.

Parameters:
SLAVE_ADDR, 7'b1010101, 7-bit bus address this target answers to
SYNC_STAGES, 2, synchronizer flops on scl and sda inputs (min 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
scl  input  1  bus clock (pulled up externally; tri1 on bench)
sda  inout  1  bus data, open-drain: driven 0 or released to z, never driven 1
tx_data  input  8  byte returned on a read; sampled on cycle after tx_req
ack_en  input  1  1 = ACK written data bytes, 0 = NACK them (address ACK unaffected)
rx_data  output  8  last byte received in a write
rx_valid  output  1  one-clk pulse when rx_data updates
tx_req  output  1  one-clk pulse requesting next read byte
rw_dir  output  1  R/W bit of current transfer (1 = read)
addr_match  output  1  high from address ACK until STOP/START
nack_rx  output  1  one-clk pulse when master NACKs a read byte
busy  output  1  high between START and STOP

Behaviour:
- Reset (reset=0, async): sda released (z), rx_data=0, all other outputs 0, state IDLE, counters 0. Reset mid-transfer releases sda immediately.
- Inputs pass SYNC_STAGES flops then one history flop; edges detected on synchronized values. All decisions use synchronized signals; latency input edge -> action = SYNC_STAGES+1 clks.
- START: sda fall while scl high; from ANY state (repeated start included) -> ADDR, bit counter 0, busy=1, addr_match=0.
- STOP: sda rise while scl high; from any state -> IDLE, release sda, busy=0, addr_match=0. Partial byte discarded, no rx_valid.
- Data sampled on scl rising edge; sda changes only in the clk after a detected scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR: shift 8 bits MSB first (7 addr + R/W). After 8th rising: match -> on next falling drive sda=0, rw_dir latched, addr_match=1, -> ADDR_ACK; if rw=1 pulse tx_req at same falling edge. Mismatch -> WAIT_STOP, sda never driven.
- ADDR_ACK: hold sda=0 through ack clock; on following falling edge: rw=0 -> release, WR_DATA; rw=1 -> load tx_data into shift reg, drive MSB, RD_DATA.
- WR_DATA: 8 rising edges shift in; after 8th: rx_data<=byte, rx_valid pulse (1 clk); on falling: ack_en=1 drive 0, else release; -> WR_ACK. WR_ACK: on next falling release, counter 0, -> WR_DATA (ack_en=0 -> WAIT_STOP).
- RD_DATA: each falling drives next bit (0 -> sda=0, 1 -> release). After 8th bit falling edge release sda -> RD_ACK.
- RD_ACK: sample master ack on rising. 0 -> tx_req pulse; on falling load tx_data, drive MSB, RD_DATA. 1 -> nack_rx pulse, WAIT_STOP (sda released).
- WAIT_STOP: sda released; leaves only on START/STOP.
- Bit counter 3-bit, wraps 7->0 per byte. START and STOP simultaneously impossible; scl edge coinciding with sda edge: START/STOP detection takes priority.

Optional Feature:
GENERAL_CALL_EN: when defined, address byte 0x00 with R/W=0 also matches (ACKed, addr_match=1, writes delivered on rx_data); 0x00 with R/W=1 -> WAIT_STOP, no ACK. When undefined, 0x00 is treated as mismatch like any other address.

Test Plan:
- Master writes 0xA5 to addr 0x55, ack_en=1 -> sda=0 on both ACK slots, rx_data=0xA5, rx_valid exactly one pulse, rw_dir=0, busy falls after STOP.
- Master reads from 0x55, tx_data=0xBC, master NACKs -> bus carries 1011_1100, tx_req one pulse, nack_rx one pulse, sda z after.
- Master addresses 0x2A -> sda never 0, addr_match=0, no rx_valid/tx_req, state WAIT_STOP until STOP.
- Write 0x11 then repeated START + read 0x55 with tx_data=0x3C, master ACK then NACK -> rx_data=0x11, two tx_req pulses, read bytes 0x3C,0x3C.
- STOP after 4 data bits of a write; separately reset=0 during RD_DATA driving 0 -> no rx_valid; sda z immediately on reset; next transfer works.
- GENERAL_CALL_EN defined: write 0x5A to addr 0x00 -> ACK, rx_data=0x5A; undefined: no ACK.

Source files
------------

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target with 7-bit address match, read/write data paths,
//               oversampled scl/sda and open-drain sda. No clock stretching.
//               Optional macro GENERAL_CALL_EN adds the 0x00 write address.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b1010101,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    input  logic       ack_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       rw_dir,
    output logic       addr_match,
    output logic       nack_rx,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_WR_DATA   = 3'd3,
        S_WR_ACK    = 3'd4,
        S_RD_DATA   = 3'd5,
        S_RD_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       rw_dir_q, rw_dir_d;
    logic       addr_match_q, addr_match_d;
    logic       nack_rx_q, nack_rx_d;
    logic       busy_q, busy_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       gc_hit, addr_hit;
    logic [7:0] shift_in;

    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // Qualified on the previous scl level so a coincident scl edge loses.
    assign start_det = scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_prev_q & ~sda_prev_q & sda_s;
    assign shift_in  = {shift_q[6:0], sda_s};

`ifdef GENERAL_CALL_EN
    assign gc_hit = (shift_q == 8'h00);
`else
    assign gc_hit = 1'b0;
`endif
    assign addr_hit = (shift_q[7:1] == SLAVE_ADDR) | gc_hit;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_done_d  = byte_done_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        rw_dir_d     = rw_dir_q;
        addr_match_d = addr_match_q;
        nack_rx_d    = 1'b0;
        busy_d       = busy_q;

        if (start_det) begin
            state_d      = S_ADDR;
            bit_cnt_d    = 3'd0;
            byte_done_d  = 1'b0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
        end else if (stop_det) begin
            state_d      = S_IDLE;
            bit_cnt_d    = 3'd0;
            byte_done_d  = 1'b0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (addr_hit) begin
                            sda_oe_d     = 1'b1;
                            rw_dir_d     = shift_q[0];
                            addr_match_d = 1'b1;
                            tx_req_d     = shift_q[0];
                            state_d      = S_ADDR_ACK;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_dir_q) begin
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = S_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = shift_in;
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = ack_en;
                        state_d     = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    // sda_oe_q still holds whether this byte was ACKed.
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = sda_oe_q ? S_WR_DATA : S_WAIT_STOP;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_d    = 1'b1;
                            byte_done_d = 1'b1;
                        end else begin
                            nack_rx_d = 1'b1;
                            state_d   = S_WAIT_STOP;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        shift_d     = tx_data;
                        sda_oe_d    = ~tx_data[7];
                        bit_cnt_d   = 3'd0;
                        state_d     = S_RD_DATA;
                    end
                end
                S_WAIT_STOP: sda_oe_d = 1'b0;
                S_IDLE:      sda_oe_d = 1'b0;
                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Bus idles high, so the synchronizers start there too.
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_done_q  <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            rw_dir_q     <= 1'b0;
            addr_match_q <= 1'b0;
            nack_rx_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_done_q  <= byte_done_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_req_q     <= tx_req_d;
            rw_dir_q     <= rw_dir_d;
            addr_match_q <= addr_match_d;
            nack_rx_q    <= nack_rx_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_req     = tx_req_q;
    assign rw_dir     = rw_dir_q;
    assign addr_match = addr_match_q;
    assign nack_rx    = nack_rx_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Bus-master stimulus for i2c_slave; DUT output events are
//               compared against an expected-event queue by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    localparam int         Q      = 8;
    localparam logic [2:0] EV_RX  = 3'd1;
    localparam logic [2:0] EV_TXR = 3'd2;
    localparam logic [2:0] EV_NAK = 3'd3;
    localparam logic [2:0] EV_RD  = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ack_en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, rw_dir, addr_match, nack_rx, busy;
    tri1        sda_bus;

    logic       rd_ev = 1'b0;
    logic [7:0] rd_byte = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         slave_low_cnt = 0;
    ev_t        exp_q[$];

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h55), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda_bus),
        .tx_data    (tx_data),
        .ack_en     (ack_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_req     (tx_req),
        .rw_dir     (rw_dir),
        .addr_match (addr_match),
        .nack_rx    (nack_rx),
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [2:0] k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input logic [2:0] k, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected", {21'd0, k, d}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_event", {21'd0, k, d}, {21'd0, e.kind, e.data});
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) sb_check(EV_RX, rx_data);
            if (tx_req)   sb_check(EV_TXR, 8'h00);
            if (nack_rx)  sb_check(EV_NAK, 8'h00);
            if (rd_ev)    sb_check(EV_RD, rd_byte);
        end
        if (!m_sda_low && sda_bus === 1'b0) slave_low_cnt++;
    end

    task automatic qwait();
        repeat (Q) @(posedge clk);
    endtask

    task automatic m_start();
        m_sda_low = 1'b0; qwait();
        scl = 1'b1;       qwait();
        m_sda_low = 1'b1; qwait();
        scl = 1'b0;       qwait();
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; qwait();
        scl = 1'b1;       qwait();
        m_sda_low = 1'b0; qwait();
        qwait();
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; qwait();
        scl = 1'b1;     qwait(); qwait();
        scl = 1'b0;     qwait();
    endtask

    task automatic read_bit(output logic v);
        m_sda_low = 1'b0; qwait();
        scl = 1'b1;       qwait();
        v = sda_bus;      qwait();
        scl = 1'b0;       qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic master_nack);
        logic [7:0] v;
        logic       bv;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bv);
            v[i] = bv;
        end
        rd_byte = v;
        rd_ev   = 1'b1;
        @(posedge clk);
        rd_ev   = 1'b0;
        write_bit(master_nack);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack;
        int   low_snap;

        repeat (3) @(posedge clk);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h0);
        chk("rst_flags", {26'd0, rx_valid, tx_req, rw_dir, addr_match, nack_rx, busy}, 32'h0);
        chk("rst_sda", {31'd0, sda_bus}, 32'h1);
        reset = 1'b1;
        repeat (4) @(posedge clk);

        // Write 0xA5 to 0x55
        ack_en = 1'b1;
        expect_ev(EV_RX, 8'hA5);
        m_start();
        chk("wr_busy", {31'd0, busy}, 32'h1);
        write_byte(8'hAA, ack);
        chk("wr_addr_ack", {31'd0, ack}, 32'h0);
        chk("wr_status", {29'd0, addr_match, rw_dir, busy}, 32'b101);
        write_byte(8'hA5, ack);
        chk("wr_data_ack", {31'd0, ack}, 32'h0);
        m_stop();
        chk("wr_rx_data", {24'd0, rx_data}, 32'hA5);
        chk("wr_after_stop", {30'd0, busy, addr_match}, 32'h0);

        // Read 0xBC from 0x55, master NACKs
        tx_data = 8'hBC;
        expect_ev(EV_TXR, 8'h00);
        expect_ev(EV_RD, 8'hBC);
        expect_ev(EV_NAK, 8'h00);
        m_start();
        write_byte(8'hAB, ack);
        chk("rd_addr_ack", {31'd0, ack}, 32'h0);
        chk("rd_rw_dir", {31'd0, rw_dir}, 32'h1);
        read_byte(1'b1);
        m_stop();
        chk("rd_sda_released", {31'd0, sda_bus}, 32'h1);

        // Address mismatch 0x2A
        low_snap = slave_low_cnt;
        m_start();
        write_byte(8'h54, ack);
        chk("mm_addr_nack", {31'd0, ack}, 32'h1);
        write_byte(8'h00, ack);
        chk("mm_data_nack", {31'd0, ack}, 32'h1);
        chk("mm_status", {30'd0, addr_match, busy}, 32'b01);
        chk("mm_never_low", slave_low_cnt - low_snap, 32'd0);
        m_stop();

        // Write 0x11, repeated START, read 0x3C twice
        tx_data = 8'h3C;
        expect_ev(EV_RX, 8'h11);
        expect_ev(EV_TXR, 8'h00);
        expect_ev(EV_RD, 8'h3C);
        expect_ev(EV_TXR, 8'h00);
        expect_ev(EV_RD, 8'h3C);
        expect_ev(EV_NAK, 8'h00);
        m_start();
        write_byte(8'hAA, ack);
        write_byte(8'h11, ack);
        chk("rs_data_ack", {31'd0, ack}, 32'h0);
        m_start();
        chk("rs_match_cleared", {31'd0, addr_match}, 32'h0);
        write_byte(8'hAB, ack);
        chk("rs_addr_ack", {31'd0, ack}, 32'h0);
        read_byte(1'b0);
        read_byte(1'b1);
        m_stop();
        chk("rs_rx_data", {24'd0, rx_data}, 32'h11);

        // STOP after four data bits of a write
        m_start();
        write_byte(8'hAA, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b0);
        m_stop();
        chk("partial_busy", {31'd0, busy}, 32'h0);
        chk("partial_rx_data", {24'd0, rx_data}, 32'h11);

        // Reset while driving a 0 data bit
        expect_ev(EV_TXR, 8'h00);
        m_start();
        write_byte(8'hAB, ack);
        chk("rst_mid_low", {31'd0, sda_bus}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_mid_sda_z", {31'd0, sda_bus}, 32'h1);
        chk("rst_mid_flags", {21'd0, rx_data, busy, addr_match, rw_dir}, 32'h0);
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        m_stop();

        // Recovery write
        expect_ev(EV_RX, 8'h77);
        m_start();
        write_byte(8'hAA, ack);
        chk("rec_addr_ack", {31'd0, ack}, 32'h0);
        write_byte(8'h77, ack);
        m_stop();

        // General call
`ifdef GENERAL_CALL_EN
        expect_ev(EV_RX, 8'h5A);
        m_start();
        write_byte(8'h00, ack);
        chk("gc_addr_ack", {31'd0, ack}, 32'h0);
        write_byte(8'h5A, ack);
        m_stop();
        chk("gc_rx_data", {24'd0, rx_data}, 32'h5A);
`else
        m_start();
        write_byte(8'h00, ack);
        chk("gc_addr_nack", {31'd0, ack}, 32'h1);
        write_byte(8'h5A, ack);
        m_stop();
        chk("gc_rx_data", {24'd0, rx_data}, 32'h77);
`endif

        repeat (4) @(posedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
